// File: rtl/demux1x2_stream.sv
// Registered 1:2 stream demux: each output channel is a one-entry valid/ready buffer.
// Optional per-channel delivered-word counters are enabled by defining DEMUX_CNT_EN.
module demux1x2_stream_chan #(
  parameter int DATAWIDTH = 8
`ifdef DEMUX_CNT_EN
  , parameter int CNTWIDTH = 16
`endif
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] a,
  input  logic                 d_ready,
  output logic [DATAWIDTH-1:0] d,
  output logic                 d_valid,
  output logic                 open
`ifdef DEMUX_CNT_EN
  , output logic [CNTWIDTH-1:0] cnt
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_nxt;
  logic   drain;

  assign drain = d_valid && d_ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    d_valid   = 1'b0;
    case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL: begin
        d_valid = 1'b1;
        if (d_ready && !load) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Free slot now, or the held word leaves on this same edge.
  assign open = !d_valid || d_ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)      d <= '0;
    else if (load) d <= a;
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)       cnt <= '0;
    else if (drain) cnt <= cnt + 1'b1;
  end
`else
  logic unused_drain;
  assign unused_drain = drain;
`endif
endmodule

module demux1x2_stream #(
  parameter int DATAWIDTH = 8,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] a,
  input  logic                 sel,
  input  logic                 a_valid,
  output logic                 a_ready,
  output logic [DATAWIDTH-1:0] d0,
  output logic                 d0_valid,
  input  logic                 d0_ready,
  output logic [DATAWIDTH-1:0] d1,
  output logic                 d1_valid,
  input  logic                 d1_ready
`ifdef DEMUX_CNT_EN
  , output logic [CNTWIDTH-1:0] cnt0
  , output logic [CNTWIDTH-1:0] cnt1
`endif
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]                load, open, d_valid, d_ready;
  logic [NUM_CH-1:0][DATAWIDTH-1:0] d;
`ifdef DEMUX_CNT_EN
  logic [NUM_CH-1:0][CNTWIDTH-1:0]  cnt;
`endif

  if (CNTWIDTH < 1) begin : g_bad_cntwidth
    $error("CNTWIDTH must be at least 1");
  end

  // Acceptance looks only at the selected channel, so a stalled peer never blocks.
  assign a_ready = open[sel];
  assign d_ready = {d1_ready, d0_ready};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign load[g] = a_valid && a_ready && (sel == 1'(g));

    demux1x2_stream_chan #(
      .DATAWIDTH (DATAWIDTH)
`ifdef DEMUX_CNT_EN
      , .CNTWIDTH(CNTWIDTH)
`endif
    ) u_chan (
      .Clk     (Clk),
      .Rst     (Rst),
      .load    (load[g]),
      .a       (a),
      .d_ready (d_ready[g]),
      .d       (d[g]),
      .d_valid (d_valid[g]),
      .open    (open[g])
`ifdef DEMUX_CNT_EN
      , .cnt   (cnt[g])
`endif
    );
  end

  assign d0       = d[0];
  assign d1       = d[1];
  assign d0_valid = d_valid[0];
  assign d1_valid = d_valid[1];
`ifdef DEMUX_CNT_EN
  assign cnt0 = cnt[0];
  assign cnt1 = cnt[1];
`endif
endmodule

// File: doc/demux1x2_stream.md
# demux1x2_stream

Registered 1-to-2 stream demultiplexer, the counterpart of the 2:1 datapath mux. One input word with a select bit is routed to one of two output channels. Each output channel has a one-entry holding register with valid/ready handshaking, so an output that stalls does not block traffic to the other output. It sits in the datapath library wherever a single producer fans out to two consumers.

## Interface
- DATAWIDTH, 8, width of the data word on the input and on each output.
- CNTWIDTH, 16, width of each per-channel transfer counter; used only when DEMUX_CNT_EN is defined.

- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-low reset.
- a  in  DATAWIDTH  input data word.
- sel  in  1  destination select, sampled with `a`: 0 routes to channel 0, 1 routes to channel 1.
- a_valid  in  1  input word and `sel` are valid.
- a_ready  out  1  block can accept the input this cycle; combinational.
- d0 / d1  out  DATAWIDTH  registered data for channel 0 / channel 1.
- d0_valid / d1_valid  out  1  the channel register holds a word.
- d0_ready / d1_ready  in  1  the consumer takes the word this cycle.
- cnt0 / cnt1  out  CNTWIDTH  count of words delivered on each channel. Present only with DEMUX_CNT_EN.

## Operation
- Each channel is a 2-state FSM: EMPTY (dN_valid=0) or FULL (dN_valid=1).
- Input transfer happens when a_valid && a_ready.
- a_ready = !dS_valid || dS_ready, where S = sel. It depends only on the selected channel.
- Output transfer on channel N happens when dN_valid && dN_ready.
- Channel N, with load = input transfer && sel==N:
  - EMPTY, load: go to FULL; dN <= a.
  - EMPTY, no load: stay EMPTY; dN holds its value.
  - FULL, output transfer and no load: go to EMPTY; dN holds its stale value.
  - FULL, output transfer and load: stay FULL; dN <= a. This is back-to-back streaming with no bubble.
  - FULL, no output transfer: stay FULL; dN and dN_valid stay stable. The unselected input is not accepted.
- The two channels are independent. A stall on channel 0 does not affect acceptance of words with sel=1.
- Ordering is preserved per channel. There is no ordering guarantee between channels.
- No data is dropped or duplicated. Every accepted word appears exactly once on exactly one output.
- The input side must hold a, sel and a_valid stable until a_ready. This is not checked by the block.

## Timing
- Reset (Rst=0, asynchronous): d0_valid=0, d1_valid=0, d0=0, d1=0, cnt0=0, cnt1=0. a_ready reads 1 while in reset, because both channels are EMPTY.
- Reset deasserting mid-transfer discards all held words. No partial state survives reset.
- Latency: a word accepted at rising edge k is visible on dN with dN_valid=1 after edge k.
- Throughput: 1 word/cycle per channel when the consumer holds dN_ready=1.
- a_ready is a combinational path from sel, dS_valid and dS_ready. There is no path from a or a_valid to a_ready.
- dN_valid must not drop without an output transfer. dN must not change while dN_valid && !dN_ready.

## Configuration
- DEMUX_CNT_EN defined:
  - cnt0 and cnt1 ports exist.
  - cntN increments by 1 on each output transfer on channel N.
  - Counters wrap from 2^CNTWIDTH-1 to 0.
  - Counters reset to 0 on Rst.
- DEMUX_CNT_EN not defined: the cnt ports and counter registers are absent. Routing and handshake behaviour is identical.

## Test plan
- Reset: assert Rst=0 mid-stream with d0 FULL. Required: d0_valid=0, d0=0, a_ready=1 immediately, without waiting for a clock edge.
- Single route: a=8'hA5, sel=1, a_valid=1 for one cycle, d1_ready=0.
  - Required: d1=8'hA5, d1_valid=1 from the next cycle and held stable.
  - Required: d0_valid stays 0.
- Streaming: 8 words 8'h01..8'h08 with sel=0, d0_ready=1 held high. Required: a_ready=1 every cycle and d0 sequence 01..08 on consecutive cycles.
- Independent stall:
  - Setup: d0 FULL with 8'h11, d0_ready=0.
  - Present sel=0: required a_ready=0.
  - Present sel=1, a=8'h22: required a_ready=1 and d1=8'h22 next cycle, with d0 still 8'h11.
- Simultaneous drain and load: d0 FULL with 8'h33, d0_ready=1, input a=8'h44, sel=0. Required: d0=8'h44 and d0_valid=1 next cycle, with no empty cycle.
- Counter wrap (DEMUX_CNT_EN, CNTWIDTH=4): 17 transfers on channel 1. Required: cnt1 reads 1 and cnt0 reads 0.
